signature_capture: RTL and testbench
====================================

SIGNATURE_CAPTURE -- requirements
Module: signature_capture

Interface
REQ-001 SHALL have parameter REGIONS, default 2, number of independent signature address windows (1..4).
REQ-002 SHALL have parameter DEPTH, default 16, record FIFO depth, power of two (4..256).
REQ-003 SHALL have parameter MASK, default 1; 1 = zero unwritten bytes in output data, 0 = pass raw mem_wdata.
REQ-004 SHALL have parameter OFFW, default 16, width of the word-offset field.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports mem_valid  input  1, mem_addr  input  32, mem_wdata  input  32, mem_wstrb  input  4: the data-memory request being monitored.
REQ-008 SHALL have ports region_beg, region_end  input  32*REGIONS  inclusive byte-address bounds, region i at bits [32i+31:32i].
REQ-009 SHALL have port region_en  input  REGIONS  per-window enable.
REQ-010 SHALL have ports tohost_addr  input  32 and tohost_en  input  1: end-of-test mailbox.
REQ-011 SHALL have ports out_valid  output  1 and out_ready  input  1: record stream handshake.
REQ-012 SHALL have ports out_region  output  2, out_offset  output  OFFW, out_data  output  32, out_strb  output  4: record payload.
REQ-013 SHALL have ports overflow  output  1 (sticky), drop_cnt  output  16, hit_cnt  output  32, done  output  1.

Function
REQ-014 Hit: mem_valid=1, |mem_wstrb=1, region_en[i]=1, and region_beg[i][31:2] <= mem_addr[31:2] <= region_end[i][31:2]; lowest matching i wins.
REQ-015 Reads (mem_wstrb=0) and misses SHALL produce no record and change no counter.
REQ-016 Record = {i, (mem_addr[31:2]-region_beg[i][31:2]) truncated to OFFW, data, mem_wstrb}; with MASK=1, byte k of data = 0 when mem_wstrb[k]=0.
REQ-017 A hit on cycle n SHALL be written into the FIFO at edge n; out_valid SHALL rise at edge n when FIFO was empty (one-cycle latency, show-ahead).
REQ-018 Payload SHALL hold stable while out_valid=1 and out_ready=0; pop occurs on edge with out_valid=1 and out_ready=1.
REQ-019 Records SHALL leave in acceptance order; pointers wrap modulo DEPTH.
REQ-020 Full FIFO with simultaneous pop SHALL accept the push (count unchanged); full without pop SHALL drop the hit, set overflow, increment drop_cnt saturating at 16'hFFFF.
REQ-021 hit_cnt SHALL increment once per accepted record, wrapping at 2^32.
REQ-022 State machine: CAPTURE (reset), DRAIN, DONE.
REQ-023 CAPTURE -> DRAIN when mem_valid=1, tohost_en=1, mem_addr[31:2]=tohost_addr[31:2], |mem_wstrb=1, mem_wdata[0]=1; a hit in that same cycle SHALL still be captured.
REQ-024 In DRAIN and DONE new hits SHALL be ignored (no push, no counter change, no overflow).
REQ-025 DRAIN -> DONE on the edge the FIFO becomes empty (or immediately next edge if already empty); done=1 only in DONE.
REQ-026 DONE SHALL persist until reset; further tohost writes are ignored.

Reset
REQ-027 rst=0 SHALL asynchronously force: state CAPTURE, FIFO empty, out_valid=0, out_region/out_offset/out_data/out_strb=0, overflow=0, drop_cnt=0, hit_cnt=0, done=0.
REQ-028 Reset asserted mid-drain SHALL discard all buffered records; capture resumes on the first edge after rst=1.

Verification
REQ-029 Region0=0x2000..0x200F enabled, store 0x2008 data 0xAABBCCDD strb 0xF, out_ready=1 -> next cycle record {0,2,0xAABBCCDD,0xF}, hit_cnt=1.
REQ-030 MASK=1, store 0x2004 data 0x11223344 strb 0x3 -> out_data=0x00003344, out_strb=0x3; read at 0x2004 -> no record.
REQ-031 Overlapping regions 0 and 1 both covering 0x3000, store there -> out_region=0 only; region_en[0]=0 -> out_region=1.
REQ-032 DEPTH=4, out_ready=0, six hits -> four records held, overflow=1, drop_cnt=2; then out_ready=1 -> first four in order, FIFO empty.
REQ-033 Three buffered records, out_ready=0, tohost write 0x1 -> DRAIN, later hits ignored, done=0; out_ready=1 -> three pops, done=1 the edge FIFO empties.
REQ-034 rst=0 asserted in DRAIN with two records buffered -> all outputs zero immediately; after release a new hit is captured normally.

Source files
------------

// File: rtl/signature_capture.sv
// Signature capture: records stores that fall into programmable address windows
// into a show-ahead FIFO and drains it after the end-of-test mailbox write.
module signature_capture #(
    parameter int REGIONS = 2,
    parameter int DEPTH   = 16,
    parameter int MASK    = 1,
    parameter int OFFW    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    input  logic [32*REGIONS-1:0]   region_beg,
    input  logic [32*REGIONS-1:0]   region_end,
    input  logic [REGIONS-1:0]      region_en,
    input  logic [31:0]             tohost_addr,
    input  logic                    tohost_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_region,
    output logic [OFFW-1:0]         out_offset,
    output logic [31:0]             out_data,
    output logic [3:0]              out_strb,
    output logic                    overflow,
    output logic [15:0]             drop_cnt,
    output logic [31:0]             hit_cnt,
    output logic                    done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]      region;
        logic [OFFW-1:0] offset;
        logic [31:0]     data;
        logic [3:0]      strb;
    } rec_t;

    state_e          state_q, state_d;
    rec_t            mem_q [DEPTH];
    rec_t            head_q, head_d;
    rec_t            rec_s;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [31:0]     hit_cnt_q, hit_cnt_d;
    logic            done_q, done_d;

    logic [REGIONS-1:0] match_s;
    logic [1:0]         sel_s;
    logic [OFFW-1:0]    off_s;
    logic [31:0]        data_s;
    logic               store_s, tohost_s, hit_ok_s, pop_s, push_s, drop_s, full_s;
    logic               unused_s;

    // Address bits [1:0] never take part in word-granular matching.
    assign unused_s = ^{mem_addr[1:0], tohost_addr[1:0], region_beg, region_end};

    // Window match; descending scan so the lowest matching window wins.
    always_comb begin
        match_s = '0;
        sel_s   = 2'd0;
        off_s   = '0;
        for (int i = 0; i < REGIONS; i++) begin
            match_s[i] = region_en[i]
                       && (mem_addr[31:2] >= region_beg[32*i+2 +: 30])
                       && (mem_addr[31:2] <= region_end[32*i+2 +: 30]);
        end
        for (int i = REGIONS - 1; i >= 0; i--) begin
            sel_s = match_s[i] ? 2'(i) : sel_s;
            off_s = match_s[i] ? OFFW'(mem_addr[31:2] - region_beg[32*i+2 +: 30]) : off_s;
        end
    end

    // Record payload with optional masking of unwritten bytes.
    always_comb begin
        data_s = mem_wdata;
        for (int k = 0; k < 4; k++) begin
            data_s[8*k +: 8] = ((MASK != 0) && !mem_wstrb[k]) ? 8'h00 : mem_wdata[8*k +: 8];
        end
        rec_s = '{region: sel_s, offset: off_s, data: data_s, strb: mem_wstrb};
    end

    assign store_s   = mem_valid && (|mem_wstrb);
    assign tohost_s  = store_s && tohost_en && (mem_addr[31:2] == tohost_addr[31:2]) && mem_wdata[0];
    assign hit_ok_s  = (state_q == ST_CAPTURE) && store_s && (|match_s);
    assign pop_s     = out_valid_q && out_ready;
    assign full_s    = (count_q == CW'(DEPTH));
    assign push_s    = hit_ok_s && (!full_s || pop_s);
    assign drop_s    = hit_ok_s && full_s && !pop_s;
    assign rd_next_s = rd_ptr_q + AW'(1);

    // FIFO bookkeeping, show-ahead head register and counters.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_next_s : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A push becomes the head when it lands in an empty (or emptying) FIFO.
        if (count_d == CW'(0)) begin
            head_d = '0;
        end else if ((count_q == CW'(0)) || (pop_s && (count_q == CW'(1)))) begin
            head_d = rec_s;
        end else if (pop_s) begin
            head_d = mem_q[rd_next_s];
        end else begin
            head_d = head_q;
        end
        out_valid_d = (count_d != CW'(0));
        overflow_d  = overflow_q | drop_s;
        drop_cnt_d  = (drop_s && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        hit_cnt_d   = push_s ? hit_cnt_q + 32'd1 : hit_cnt_q;
    end

    // Capture / drain / done sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CAPTURE: state_d = tohost_s ? ST_DRAIN : ST_CAPTURE;
            ST_DRAIN:   state_d = (count_d == CW'(0)) ? ST_DONE : ST_DRAIN;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_CAPTURE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    // Record storage; not reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rec_s;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CAPTURE;
            head_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 16'd0;
            hit_cnt_q   <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            done_q      <= done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_region = head_q.region;
    assign out_offset = head_q.offset;
    assign out_data   = head_q.data;
    assign out_strb   = head_q.strb;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign hit_cnt    = hit_cnt_q;
    assign done       = done_q;

endmodule

// File: tb/tb_signature_capture.sv
// Directed self-checking bench for signature_capture (DEPTH=4, two windows).
module tb_signature_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [63:0] region_beg, region_end;
    logic [1:0]  region_en;
    logic [31:0] tohost_addr;
    logic        tohost_en;
    logic        out_valid, out_ready;
    logic [1:0]  out_region;
    logic [15:0] out_offset;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [31:0] hit_cnt;
    logic        done;

    int checks = 0;
    int errors = 0;

    signature_capture #(.REGIONS(2), .DEPTH(4), .MASK(1), .OFFW(16)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .region_beg(region_beg), .region_end(region_end), .region_en(region_en),
        .tohost_addr(tohost_addr), .tohost_en(tohost_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_region(out_region), .out_offset(out_offset), .out_data(out_data), .out_strb(out_strb),
        .overflow(overflow), .drop_cnt(drop_cnt), .hit_cnt(hit_cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        tick();
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_data"}, out_data, 32'd0);
        check_eq({tag, "_payload"}, {14'd0, out_region, out_offset}, 32'd0);
        check_eq({tag, "_strb"}, {28'd0, out_strb}, 32'd0);
        check_eq({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
        check_eq({tag, "_drop"}, {16'd0, drop_cnt}, 32'd0);
        check_eq({tag, "_hits"}, hit_cnt, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'h0;
        region_beg = {32'h0000_3000, 32'h0000_2000};
        region_end = {32'h0000_30FF, 32'h0000_200F};
        region_en = 2'b11; tohost_addr = 32'h0000_1000; tohost_en = 1'b1; out_ready = 1'b1;
        #3;
        check_zero_outputs("reset");
        tick(); tick();
        rst = 1'b1;
        tick();

        // Basic full-word store
        store(32'h0000_2008, 32'hAABB_CCDD, 4'hF);
        check_eq("t1_valid", {31'd0, out_valid}, 32'd1);
        check_eq("t1_region", {30'd0, out_region}, 32'd0);
        check_eq("t1_offset", {16'd0, out_offset}, 32'd2);
        check_eq("t1_data", out_data, 32'hAABB_CCDD);
        check_eq("t1_strb", {28'd0, out_strb}, 32'hF);
        check_eq("t1_hits", hit_cnt, 32'd1);
        tick();
        check_eq("t1_popped", {31'd0, out_valid}, 32'd0);

        // Partial store masking, then a read that must not record
        store(32'h0000_2004, 32'h1122_3344, 4'h3);
        check_eq("t2_data", out_data, 32'h0000_3344);
        check_eq("t2_strb", {28'd0, out_strb}, 32'h3);
        check_eq("t2_offset", {16'd0, out_offset}, 32'd1);
        tick();
        store(32'h0000_2004, 32'h1122_3344, 4'h0);
        check_eq("t2_read_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t2_read_hits", hit_cnt, 32'd2);
        store(32'h0000_5000, 32'h1, 4'hF);
        check_eq("t2_miss_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t2_miss_hits", hit_cnt, 32'd2);

        // Overlapping windows: lowest enabled wins
        region_end[31:0] = 32'h0000_30FF;
        store(32'h0000_3000, 32'h0000_0077, 4'hF);
        check_eq("t3_region0", {30'd0, out_region}, 32'd0);
        check_eq("t3_offset0", {16'd0, out_offset}, 32'h400);
        tick();
        region_en = 2'b10;
        store(32'h0000_3000, 32'h0000_0078, 4'hF);
        check_eq("t3_region1", {30'd0, out_region}, 32'd1);
        check_eq("t3_offset1", {16'd0, out_offset}, 32'd0);
        check_eq("t3_hits", hit_cnt, 32'd4);
        tick();
        region_en = 2'b11;
        region_end[31:0] = 32'h0000_200F;

        // Overflow: six hits into a four-entry FIFO with no consumer
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            store(32'h0000_2000 + 32'((k % 4) * 4), 32'h100 + 32'(k), 4'hF);
        end
        check_eq("t4_valid", {31'd0, out_valid}, 32'd1);
        check_eq("t4_ovf", {31'd0, overflow}, 32'd1);
        check_eq("t4_drop", {16'd0, drop_cnt}, 32'd2);
        check_eq("t4_hits", hit_cnt, 32'd8);
        check_eq("t4_stable", out_data, 32'h100);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t4_order%0d", k), out_data, 32'h100 + 32'(k));
            tick();
        end
        check_eq("t4_empty", {31'd0, out_valid}, 32'd0);

        // Drain sequence after the mailbox write
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            store(32'h0000_2000 + 32'(k * 4), 32'h200 + 32'(k), 4'hF);
        end
        store(32'h0000_1000, 32'h0000_0001, 4'hF);
        store(32'h0000_2000, 32'h0000_0999, 4'hF);
        check_eq("t5_ignored_hits", hit_cnt, 32'd11);
        check_eq("t5_drop_kept", {16'd0, drop_cnt}, 32'd2);
        check_eq("t5_not_done", {31'd0, done}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("t5_drain%0d", k), out_data, 32'h200 + 32'(k));
            check_eq($sformatf("t5_done_pre%0d", k), {31'd0, done}, 32'd0);
            tick();
        end
        check_eq("t5_done", {31'd0, done}, 32'd1);
        check_eq("t5_empty", {31'd0, out_valid}, 32'd0);
        store(32'h0000_1000, 32'h0000_0001, 4'hF);
        store(32'h0000_2000, 32'h0000_0123, 4'hF);
        check_eq("t5_done_hold", {31'd0, done}, 32'd1);
        check_eq("t5_hits_hold", hit_cnt, 32'd11);
        check_eq("t5_no_record", {31'd0, out_valid}, 32'd0);

        // Reset in DRAIN with two records buffered
        rst = 1'b0;
        tick();
        rst = 1'b1;
        out_ready = 1'b0;
        store(32'h0000_2000, 32'h0000_0301, 4'hF);
        store(32'h0000_2004, 32'h0000_0302, 4'hF);
        store(32'h0000_1000, 32'h0000_0001, 4'hF);
        check_eq("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        check_eq("t6_pre_hits", hit_cnt, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("t6_rst");
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        store(32'h0000_200C, 32'h0000_0055, 4'hF);
        check_eq("t6_valid", {31'd0, out_valid}, 32'd1);
        check_eq("t6_data", out_data, 32'h0000_0055);
        check_eq("t6_offset", {16'd0, out_offset}, 32'd3);
        check_eq("t6_hits", hit_cnt, 32'd1);
        check_eq("t6_done", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
